// File: rtl/shift_sequencer.sv
// -----------------------------------------------------------------------------
// shift_sequencer
//
// Purpose:
//   Command-driven controller for an external 8-bit universal shift register.
//   It accepts one command at a time: no-op, shift right, shift left, or
//   load-then-shift-right. Shift counts of 9..15 are clamped to 8. It drives
//   the register's enable, mode select, load value and serial fill bits, and
//   it pulses 'done' once when a command completes. 'abort' cancels a command
//   in LOAD or SHIFT, and no 'done' pulse follows.
//
// Handshake:
//   A command transfers on a rising edge of 'clock' where cmdvalid and
//   cmdready are both high. cmdready is high only in IDLE. The requester may
//   keep cmdvalid high while the sequencer is busy. That command transfers on
//   the first IDLE edge.
//
// Configuration macro:
//   SHIFTSEQ_ROTATE_EN - when defined, the serial fill bits come from the
//   register's own end bits (rotate): serialinr = regout[0] and
//   serialinl = regout[7]. When undefined, both fill bits follow sdin.
//
// Ports:
//   clock       in   system clock, rising edge
//   resetn      in   asynchronous active-low reset
//   cmdvalid    in   command pending
//   cmdready    out  command can be accepted (IDLE)
//   cmdop       in   [1:0] 00 nop, 01 right, 10 left, 11 load+right
//   cmdcount    in   [3:0] shift cycles (9..15 treated as 8)
//   cmddata     in   [7:0] load value for op 11
//   sdin        in   serial fill bit (non-rotate build)
//   abort       in   synchronous cancel (LOAD/SHIFT only)
//   regout      in   [7:0] parallel output of the controlled register
//   enable      out  register enable
//   s1, s0      out  register mode: 00 hold, 01 right, 10 left, 11 load
//   parallelin  out  [7:0] register load value (latched command data)
//   serialinr   out  right-shift fill bit
//   serialinl   out  left-shift fill bit
//   busy        out  high in any state other than IDLE
//   done        out  one-cycle completion pulse
//   dbg_state   out  [1:0] current FSM state encoding
// -----------------------------------------------------------------------------
module shift_sequencer (
    input  logic       clock,
    input  logic       resetn,
    input  logic       cmdvalid,
    output logic       cmdready,
    input  logic [1:0] cmdop,
    input  logic [3:0] cmdcount,
    input  logic [7:0] cmddata,
    input  logic       sdin,
    input  logic       abort,
    input  logic [7:0] regout,
    output logic       enable,
    output logic       s1,
    output logic       s0,
    output logic [7:0] parallelin,
    output logic       serialinr,
    output logic       serialinl,
    output logic       busy,
    output logic       done,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_LEFT  = 2'b10;
    localparam logic [1:0] OP_LOADR = 2'b11;

    state_t     r_state;
    state_t     w_next_state;
    logic [1:0] r_op;
    logic [3:0] r_count;   // shift cycles still to run
    logic [7:0] r_data;

    logic       w_handshake;
    logic [3:0] w_count_clamped;

    assign w_handshake     = (r_state == ST_IDLE) && cmdvalid;
    assign w_count_clamped = (cmdcount > 4'd8) ? 4'd8 : cmdcount;

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (cmdvalid) begin
                    if (cmdop == OP_LOADR)
                        w_next_state = ST_LOAD;
                    else if ((cmdop != OP_NOP) && (w_count_clamped != 4'd0))
                        w_next_state = ST_SHIFT;
                    else
                        w_next_state = ST_DONE;
                end
            end
            ST_LOAD: begin
                if (abort)
                    w_next_state = ST_IDLE;
                else if (r_count != 4'd0)
                    w_next_state = ST_SHIFT;
                else
                    w_next_state = ST_DONE;
            end
            ST_SHIFT: begin
                // Abort takes priority over a normal finish on the last shift.
                if (abort)
                    w_next_state = ST_IDLE;
                else if (r_count == 4'd1)
                    w_next_state = ST_DONE;
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            r_state <= ST_IDLE;
        else
            r_state <= w_next_state;
    end

    // Latched command fields and remaining count
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_op    <= 2'b00;
            r_count <= 4'd0;
            r_data  <= 8'h00;
        end else if (w_handshake) begin
            r_op    <= cmdop;
            r_count <= w_count_clamped;
            r_data  <= cmddata;
        end else if (r_state == ST_SHIFT) begin
            // On abort the count is cleared so that no stale count is kept.
            if (abort)
                r_count <= 4'd0;
            else
                r_count <= r_count - 4'd1;
        end else if ((r_state == ST_LOAD) && abort) begin
            r_count <= 4'd0;
        end
    end

    // Output decode from the registered state and the latched fields only
    always_comb begin
        enable   = 1'b0;
        s1       = 1'b0;
        s0       = 1'b0;
        cmdready = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cmdready = 1'b1;
                busy     = 1'b0;
            end
            ST_LOAD: begin
                enable = 1'b1;
                s1     = 1'b1;
                s0     = 1'b1;
            end
            ST_SHIFT: begin
                enable = 1'b1;
                if (r_op == OP_LEFT) begin
                    s1 = 1'b1;
                    s0 = 1'b0;
                end else begin
                    s1 = 1'b0;
                    s0 = 1'b1;
                end
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    assign parallelin = r_data;
    assign dbg_state  = r_state;

`ifdef SHIFTSEQ_ROTATE_EN
    assign serialinr = regout[0];
    assign serialinl = regout[7];
    // sdin has no function in the rotate build.
    logic w_unused_sdin;
    assign w_unused_sdin = sdin;
`else
    assign serialinr = sdin;
    assign serialinl = sdin;
    // regout is only needed for the rotate fill.
    logic w_unused_regout;
    assign w_unused_regout = ^regout;
`endif

endmodule

// File: tb/tb_shift_sequencer.sv
// -----------------------------------------------------------------------------
// tb_shift_sequencer
//
// Bench for shift_sequencer. The bench contains a behavioural 8-bit universal
// shift register. The sequencer controls this register, so regout is real.
// Each command records its expected latency, shift count, load count and
// final register value in a queue. These values come from the table constants
// and from a reference function that works on the bench register. When the
// bench sees the done pulse, it takes the entry from the queue and compares.
// -----------------------------------------------------------------------------
module tb_shift_sequencer;

    logic       clock;
    logic       resetn;
    logic       cmdvalid;
    logic       cmdready;
    logic [1:0] cmdop;
    logic [3:0] cmdcount;
    logic [7:0] cmddata;
    logic       sdin;
    logic       abort;
    logic [7:0] regout;
    logic       enable;
    logic       s1;
    logic       s0;
    logic [7:0] parallelin;
    logic       serialinr;
    logic       serialinl;
    logic       busy;
    logic       done;
    logic [1:0] dbg_state;

    int checks;
    int failures;

    // {latency[31:24], shifts[23:16], loads[15:8], final_reg[7:0]}
    logic [31:0] exp_q[$];

    logic [7:0] reg_q;

`ifdef SHIFTSEQ_ROTATE_EN
    localparam bit ROTATE = 1'b1;
`else
    localparam bit ROTATE = 1'b0;
`endif

    shift_sequencer dut (
        .clock      (clock),
        .resetn     (resetn),
        .cmdvalid   (cmdvalid),
        .cmdready   (cmdready),
        .cmdop      (cmdop),
        .cmdcount   (cmdcount),
        .cmddata    (cmddata),
        .sdin       (sdin),
        .abort      (abort),
        .regout     (regout),
        .enable     (enable),
        .s1         (s1),
        .s0         (s0),
        .parallelin (parallelin),
        .serialinr  (serialinr),
        .serialinl  (serialinl),
        .busy       (busy),
        .done       (done),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- controlled register model ----------------
    initial reg_q = 8'h00;
    always_ff @(posedge clock) begin
        if (enable) begin
            case ({s1, s0})
                2'b01:   reg_q <= {serialinr, reg_q[7:1]};
                2'b10:   reg_q <= {reg_q[6:0], serialinl};
                2'b11:   reg_q <= parallelin;
                default: reg_q <= reg_q;
            endcase
        end
    end
    assign regout = reg_q;

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int clamp8(input logic [3:0] c);
        return (c > 4'd8) ? 8 : int'(c);
    endfunction

    // Final register value after one command, from the starting value
    function automatic logic [7:0] ref_final(input logic [7:0] start, input logic [1:0] op,
                                             input int n, input logic [7:0] data, input logic sd);
        logic [7:0] r;
        r = (op == 2'b11) ? data : start;
        if (op != 2'b00) begin
            for (int i = 0; i < n; i++) begin
                if (op == 2'b10)
                    r = {r[6:0], (ROTATE ? r[7] : sd)};
                else
                    r = {(ROTATE ? r[0] : sd), r[7:1]};
            end
        end
        return r;
    endfunction

    // ---------------- driver + scoreboard ----------------
    task automatic run_cmd(input string name, input logic [1:0] op, input logic [3:0] cnt,
                           input logic [7:0] data, input logic sd,
                           input int exp_lat, input int exp_sh);
        logic [31:0] e;
        logic [7:0]  fin;
        logic [1:0]  want_sel;
        int          k;
        int          nsh;
        int          nld;
        bit          sel_ok;
        bit          pin_ok;
        @(negedge clock);
        fin = ref_final(reg_q, op, clamp8(cnt), data, sd);
        cmdop    = op;
        cmdcount = cnt;
        cmddata  = data;
        sdin     = sd;
        cmdvalid = 1'b1;
        exp_q.push_back({exp_lat[7:0], exp_sh[7:0], ((op == 2'b11) ? 8'd1 : 8'd0), fin});
        want_sel = (op == 2'b10) ? 2'b10 : 2'b01;
        @(posedge clock);
        @(negedge clock);
        cmdvalid = 1'b0;
        k = 0; nsh = 0; nld = 0; sel_ok = 1'b1; pin_ok = 1'b1;
        while (!done && k < 40) begin
            if (enable) begin
                if ({s1, s0} == 2'b11) begin
                    nld++;
                    if (parallelin !== data) pin_ok = 1'b0;
                end else begin
                    nsh++;
                    if ({s1, s0} !== want_sel) sel_ok = 1'b0;
                end
            end
            k++;
            @(negedge clock);
        end
        e = exp_q.pop_front();
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: no done within 40 cycles", name);
            return;
        end
        chk({name, "_latency"}, k + 1, {24'd0, e[31:24]});
        chk({name, "_shifts"}, nsh, {24'd0, e[23:16]});
        chk({name, "_loads"}, nld, {24'd0, e[15:8]});
        chk({name, "_reg"}, {24'd0, reg_q}, {24'd0, e[7:0]});
        chk({name, "_sel"}, {31'd0, sel_ok}, 32'd1);
        chk({name, "_pin"}, {31'd0, pin_ok}, 32'd1);
        chk({name, "_done_busy"}, {30'd0, busy, cmdready}, 32'd2);
        chk({name, "_done_pin"}, {24'd0, parallelin}, {24'd0, data});
        @(negedge clock);
        chk({name, "_pulse_end"}, {29'd0, done, busy, cmdready}, 32'd1);
    endtask

    typedef struct {
        logic [1:0] op;
        logic [3:0] cnt;
        logic [7:0] data;
        logic       sd;
        int         lat;
        int         sh;
    } vec_t;

    vec_t vecs[10];

    initial begin
        checks   = 0;
        failures = 0;
        resetn   = 1'b0;
        cmdvalid = 1'b0;
        cmdop    = 2'b00;
        cmdcount = 4'd0;
        cmddata  = 8'h00;
        sdin     = 1'b0;
        abort    = 1'b0;

        vecs[0] = '{2'b11, 4'd0,  8'hA5, 1'b0, 2,  0};
        vecs[1] = '{2'b11, 4'd3,  8'hAA, 1'b1, 5,  3};
        vecs[2] = '{2'b10, 4'd12, 8'h00, 1'b0, 9,  8};
        vecs[3] = '{2'b01, 4'd0,  8'h11, 1'b1, 1,  0};
        vecs[4] = '{2'b00, 4'd5,  8'h22, 1'b1, 1,  0};
        vecs[5] = '{2'b01, 4'd4,  8'h33, 1'b1, 5,  4};
        vecs[6] = '{2'b10, 4'd8,  8'h44, 1'b1, 9,  8};
        vecs[7] = '{2'b11, 4'd15, 8'h3C, 1'b0, 10, 8};
        vecs[8] = '{2'b11, 4'd1,  8'h81, 1'b0, 3,  1};
        vecs[9] = '{2'b10, 4'd1,  8'h00, 1'b0, 2,  1};

        // ---- reset state ----
        #12;
        chk("rst_ready_busy", {30'd0, cmdready, busy}, 32'd2);
        chk("rst_en_sel_done", {28'd0, enable, s1, s0, done}, 32'd0);
        chk("rst_pin", {24'd0, parallelin}, 32'd0);
        chk("rst_state", {30'd0, dbg_state}, 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);

        // ---- serial fill routing ----
        sdin = 1'b1;
        #1;
        if (ROTATE) chk("fill_rot", {30'd0, serialinr, serialinl}, {30'd0, regout[0], regout[7]});
        else        chk("fill_sdin1", {30'd0, serialinr, serialinl}, 32'd3);
        sdin = 1'b0;
        #1;
        if (ROTATE) chk("fill_rot2", {30'd0, serialinr, serialinl}, {30'd0, regout[0], regout[7]});
        else        chk("fill_sdin0", {30'd0, serialinr, serialinl}, 32'd0);

        // ---- table vectors ----
        for (int i = 0; i < 10; i++) begin
            run_cmd($sformatf("vec%0d", i), vecs[i].op, vecs[i].cnt, vecs[i].data,
                    vecs[i].sd, vecs[i].lat, vecs[i].sh);
        end

        // ---- fixed register values from the requirement examples ----
        run_cmd("aa3", 2'b11, 4'd3, 8'hAA, 1'b1, 5, 3);
        if (ROTATE) chk("aa3_const", {24'd0, reg_q}, 32'h55);
        else        chk("aa3_const", {24'd0, reg_q}, 32'hF5);
        run_cmd("r81", 2'b11, 4'd1, 8'h81, 1'b0, 3, 1);
        chk("r81_const", {24'd0, reg_q}, ROTATE ? 32'hC0 : 32'h40);
        run_cmd("l81_load", 2'b11, 4'd0, 8'h81, 1'b0, 2, 0);
        run_cmd("l81", 2'b10, 4'd1, 8'h00, 1'b0, 2, 1);
        chk("l81_const", {24'd0, reg_q}, ROTATE ? 32'h03 : 32'h02);

        // ---- random commands ----
        for (int i = 0; i < 6; i++) begin
            logic [1:0] rop;
            logic [3:0] rcnt;
            int         rsh;
            rop  = 2'($urandom_range(0, 3));
            rcnt = 4'($urandom_range(0, 15));
            rsh  = (rop == 2'b00) ? 0 : clamp8(rcnt);
            run_cmd($sformatf("rnd%0d", i), rop, rcnt, 8'($urandom_range(0, 255)),
                    1'($urandom_range(0, 1)), ((rop == 2'b11) ? 1 : 0) + rsh + 1, rsh);
        end

        // ---- abort after the 2nd SHIFT cycle ----
        @(negedge clock);
        cmdop = 2'b01; cmdcount = 4'd6; cmdvalid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        cmdvalid = 1'b0;
        chk("abort_shift1", {30'd0, dbg_state}, 32'd2);
        @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        chk("abort_idle", {28'd0, busy, cmdready, done, enable}, 32'd4);
        begin
            int seen_done;
            seen_done = 0;
            for (int i = 0; i < 10; i++) begin
                if (done) seen_done++;
                @(negedge clock);
            end
            chk("abort_no_done", seen_done, 0);
        end

        // ---- abort together with cmdvalid in IDLE: the command is accepted ----
        cmdop = 2'b00; cmdvalid = 1'b1; abort = 1'b1;
        @(negedge clock);
        cmdvalid = 1'b0; abort = 1'b0;
        chk("abort_idle_accept", {30'd0, done, busy}, 32'd3);
        @(negedge clock);

        // ---- cmdvalid held while busy: accepted on the first IDLE edge ----
        cmdop = 2'b01; cmdcount = 4'd2; cmdvalid = 1'b1;
        @(negedge clock);
        cmdop = 2'b00;
        chk("hold_s0", {30'd0, cmdready, enable}, 32'd1);
        @(negedge clock);
        chk("hold_s1", {30'd0, cmdready, enable}, 32'd1);
        @(negedge clock);
        chk("hold_done1", {30'd0, cmdready, done}, 32'd1);
        @(negedge clock);
        chk("hold_idle", {30'd0, cmdready, busy}, 32'd2);
        @(negedge clock);
        cmdvalid = 1'b0;
        chk("hold_done2", {30'd0, done, enable}, 32'd2);
        @(negedge clock);

        // ---- reset during SHIFT of op 11 count 8 ----
        cmdop = 2'b11; cmdcount = 4'd8; cmddata = 8'h5A; cmdvalid = 1'b1;
        @(negedge clock);
        cmdvalid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("rst_mid_inshift", {30'd0, dbg_state}, 32'd2);
        #2;
        resetn = 1'b0;
        #1;
        chk("rst_mid_ctrl", {26'd0, enable, s1, s0, done, busy, cmdready}, 32'd1);
        chk("rst_mid_pin", {24'd0, parallelin}, 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        run_cmd("post_rst", 2'b01, 4'd2, 8'h77, 1'b1, 3, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so that the bench always terminates
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
